rv_div_unit: RTL and testbench
==============================

Name: rv_div_unit

Overview:
- Iterative RV32M divide/remainder unit downstream of the register file.
- Consumes the two read-port operands (rs1/rs2 data) plus the destination address.
- Produces a write-back triple (data, address, enable) that drives the register file's WD3/A3/WE3 inputs.
- Radix-2 restoring division, one quotient bit per cycle, with a start/busy/done handshake that stalls the core while busy.

Parameters:
- XLEN, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- funct3  input  3  100=DIV, 101=DIVU, 110=REM, 111=REMU.
- rs1_data  input  XLEN  dividend.
- rs2_data  input  XLEN  divisor.
- rd_addr  input  5  destination register.
- busy  output  1  high from the cycle after acceptance until done has been presented.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  quotient or remainder; held until the next acceptance.
- wb_addr  output  5  latched rd_addr.
- wb_en  output  1  equals done AND (wb_addr != 0).

Behaviour:
- Reset (rst=0 at a rising edge): state=IDLE; busy, done and wb_en = 0; result = 0; wb_addr = 0; all internal registers = 0.
  - Reset wins over every other input.
  - Reset mid-operation aborts the operation; no done pulse is produced.
- Acceptance: edge where state=IDLE, start=1 and funct3[2]=1.
  - Latch operands, funct3 and rd_addr.
  - start with funct3[2]=0 (MUL group) is ignored.
  - start outside IDLE is ignored; it is not queued.
- FSM: IDLE -> CALC -> DONE -> IDLE, plus the shortcut IDLE -> DONE for the special cases below.
- Signed ops (DIV, REM):
  - Divide the absolute values.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Unsigned ops use the operands directly.
- CALC:
  - Counter starts at XLEN-1 and decrements.
  - Each cycle: shift {rem, quo} left by 1; trial-subtract the divisor; set the quotient LSB if the result is non-negative.
  - Leaves to DONE after XLEN cycles.
- Latency: acceptance at edge k -> done=1 during the cycle following edge k+XLEN+1 (33 cycles for XLEN=32).
- Special cases (decided at acceptance, DONE after 1 cycle):
  - Divisor = 0: quotient = all ones; remainder = dividend (signed and unsigned).
  - Signed overflow (dividend = 0x80000000, divisor = 0xFFFFFFFF, DIV/REM only): quotient = 0x80000000; remainder = 0.
- DONE:
  - done=1 for exactly one cycle.
  - result = quotient for DIV/DIVU, remainder for REM/REMU.
  - Returns to IDLE.
  - A new start is accepted on the next edge, never in DONE itself.
- rd_addr = 0: the computation runs normally, but wb_en stays 0, preserving x0.
- Operand inputs may change freely after acceptance; only latched copies are used.

Decomposition:
- Package rv_m_pkg: funct3 encodings (DIV/DIVU/REM/REMU), state encoding (IDLE, CALC, DONE), XLEN default.
- One natural sub-module: div_core_unsigned, the unsigned XLEN-cycle shift-subtract core with start/done.
- rv_div_unit wraps div_core_unsigned and owns sign handling, special cases and write-back.

Test Plan:
- DIVU 20/3, rd=5, start at edge 0 -> done at edge 33, result=6, wb_addr=5, wb_en=1; busy high edges 1-33.
- DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; REMU 0xFFFFFFF9/2 -> 1.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0. Each has done one cycle after acceptance.
- start pulses at edges 5 and 20 with new operands during CALC -> ignored; the single done carries the first operation's result.
- rst=0 at edge 10 of an operation -> busy=0, result=0 next cycle, no done; a fresh DIVU 100/7 then yields 14.
- DIV 9/3 with rd=0 -> done=1, result=3, wb_en=0.

Source files
------------

// File: rtl/rv_m_pkg.sv
// Shared definitions for the RV32M divide/remainder slice: funct3 codes,
// controller state encoding and the default datapath width.
package rv_m_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_core_unsigned.sv
// Unsigned radix-2 restoring divider. A start pulse loads the operands; the
// core then produces one quotient bit per cycle for XLEN cycles. done is high
// during the cycle in which the final iteration is about to be clocked in, so
// quotient/remainder are final on the cycle after done.
module div_core_unsigned #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  dvsr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             active_q;

    logic [XLEN:0]    rem_shift;
    logic [XLEN+1:0]  trial;
    logic             trial_ok;
    logic [XLEN-1:0]  rem_next;

    // One shift/trial-subtract step: the extra top bit of trial is the borrow.
    always_comb begin
        rem_shift = {rem_q, quo_q[XLEN-1]};
        trial     = {1'b0, rem_shift} - {2'b00, dvsr_q};
        trial_ok  = ~trial[XLEN+1];
        rem_next  = trial_ok ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
    end

    // Operand load on start, then iterate until the counter has run out.
    always_ff @(posedge clk) begin
        if (!rst) begin
            quo_q    <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start) begin
            quo_q    <= dividend;
            rem_q    <= '0;
            dvsr_q   <= divisor;
            cnt_q    <= CNT_W'(XLEN - 1);
            active_q <= 1'b1;
        end else if (active_q) begin
            quo_q <= {quo_q[XLEN-2:0], trial_ok};
            rem_q <= rem_next;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                active_q <= 1'b0;
            end
        end
    end

    assign done      = active_q && (cnt_q == '0);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/rv_div_unit.sv
// RV32M DIV/DIVU/REM/REMU unit. Folds signed operands to magnitudes for the
// unsigned core, resolves divide-by-zero and signed overflow at acceptance,
// and drives the register-file write-back triple. All handshake outputs are
// registered one cycle behind the controller state.
module rv_div_unit
    import rv_m_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      wb_addr,
    output logic            wb_en
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t state_q;
    div_state_t state_d;

    logic            accept;
    logic            core_start;
    logic            finish;

    logic            is_signed;
    logic            is_rem;
    logic            a_neg;
    logic            b_neg;
    logic            div_zero;
    logic            sgn_ovf;
    logic            special;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN-1:0] spec_val;

    logic            op_rem_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic            special_q;
    logic [XLEN-1:0] spec_val_q;

    logic            core_last;
    logic [XLEN-1:0] core_quo;
    logic [XLEN-1:0] core_rem;
    logic [XLEN-1:0] final_val;

    // Operand decode: magnitudes for the core and the early-out result.
    always_comb begin
        is_signed = (funct3 == F3_DIV) || (funct3 == F3_REM);
        is_rem    = (funct3 == F3_REM) || (funct3 == F3_REMU);
        a_neg     = is_signed && rs1_data[XLEN-1];
        b_neg     = is_signed && rs2_data[XLEN-1];
        abs_a     = a_neg ? -rs1_data : rs1_data;
        abs_b     = b_neg ? -rs2_data : rs2_data;
        div_zero  = (rs2_data == '0);
        sgn_ovf   = is_signed && (rs1_data == INT_MIN) && (rs2_data == '1);
        special   = div_zero || sgn_ovf;
        if (div_zero) begin
            spec_val = is_rem ? rs1_data : '1;
        end else begin
            spec_val = is_rem ? '0 : INT_MIN;
        end
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: early-outs skip the iteration phase entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (core_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller strobes; only divide-group requests are taken, and only in IDLE.
    always_comb begin
        accept     = (state_q == ST_IDLE) && start && funct3[2];
        core_start = accept && !special;
        finish     = (state_q == ST_DONE);
    end

    div_core_unsigned #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (core_start),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .done      (core_last),
        .quotient  (core_quo),
        .remainder (core_rem)
    );

    // Sign restoration: quotient negative on sign mismatch, remainder follows dividend.
    always_comb begin
        if (special_q) begin
            final_val = spec_val_q;
        end else if (op_rem_q) begin
            final_val = neg_rem_q ? -core_rem : core_rem;
        end else begin
            final_val = neg_quo_q ? -core_quo : core_quo;
        end
    end

    // Request latches and registered write-back outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_rem_q   <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            special_q  <= 1'b0;
            spec_val_q <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wb_en      <= 1'b0;
            wb_addr    <= '0;
            result     <= '0;
        end else begin
            busy  <= (state_q != ST_IDLE);
            done  <= finish;
            wb_en <= finish && (wb_addr != 5'd0);
            if (accept) begin
                op_rem_q   <= is_rem;
                neg_quo_q  <= a_neg ^ b_neg;
                neg_rem_q  <= a_neg;
                special_q  <= special;
                spec_val_q <= spec_val;
                wb_addr    <= rd_addr;
            end
            if (finish) begin
                result <= final_val;
            end
        end
    end

endmodule

// File: tb/tb_rv_div_unit.sv
// Self-checking bench for rv_div_unit: a timeline model of the divide unit
// (result from plain integer arithmetic, done at a fixed latency) is compared
// against the DUT every cycle, with directed operations pinned to literals.
module tb_rv_div_unit;
    import rv_m_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  wb_addr;
    logic        wb_en;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int accepted = 0;
    bit check_en = 1'b0;

    // Model state
    bit          pending = 1'b0;
    int          acc_m;
    int          due_m;
    logic [31:0] pend_res;
    logic        exp_busy    = 1'b0;
    logic        exp_done    = 1'b0;
    logic [31:0] exp_result  = '0;
    logic [4:0]  exp_wb_addr = '0;
    logic        exp_wb_en   = 1'b0;

    rv_div_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_addr  (rd_addr),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .wb_addr  (wb_addr),
        .wb_en    (wb_en)
    );

    always #5 clk = ~clk;

    function automatic bit isSpecial(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bit sgn;
        sgn = (f3 == F3_DIV) || (f3 == F3_REM);
        return (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] refResult(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bit sgn;
        bit want_rem;
        int sa;
        int sb;
        logic [31:0] q;
        logic [31:0] r;
        sgn      = (f3 == F3_DIV) || (f3 == F3_REM);
        want_rem = (f3 == F3_REM) || (f3 == F3_REMU);
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return want_rem ? r : q;
    endfunction

    // Timeline model: what the outputs must show after each rising edge.
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            pending     = 1'b0;
            exp_busy    = 1'b0;
            exp_done    = 1'b0;
            exp_result  = '0;
            exp_wb_addr = '0;
            exp_wb_en   = 1'b0;
        end else begin
            if (pending && cyc > due_m) pending = 1'b0;
            exp_busy = pending && (cyc > acc_m);
            exp_done = pending && (cyc == due_m);
            if (exp_done) exp_result = pend_res;
            exp_wb_en = exp_done && (exp_wb_addr != 5'd0);
            if (!pending && start && funct3[2]) begin
                pending     = 1'b1;
                acc_m       = cyc;
                due_m       = cyc + (isSpecial(funct3, rs1_data, rs2_data) ? 1 : 33);
                pend_res    = refResult(funct3, rs1_data, rs2_data);
                exp_wb_addr = rd_addr;
                accepted++;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("busy",    {31'd0, busy},    {31'd0, exp_busy});
            checkOutput("done",    {31'd0, done},    {31'd0, exp_done});
            checkOutput("result",  result,           exp_result);
            checkOutput("wb_addr", {27'd0, wb_addr}, {27'd0, exp_wb_addr});
            checkOutput("wb_en",   {31'd0, wb_en},   {31'd0, exp_wb_en});
        end
    end

    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        start    = 1'b1;
        funct3   = f3;
        rs1_data = a;
        rs2_data = b;
        rd_addr  = rd;
    endtask

    task automatic scramble();
        start    = 1'b0;
        funct3   = 3'($urandom);
        rs1_data = $urandom;
        rs2_data = $urandom;
        rd_addr  = 5'($urandom);
    endtask

    task automatic runOp(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] lit, input int lat);
        int acc_edge;
        bit seen;
        @(negedge clk);
        applyStimulus(f3, a, b, rd);
        acc_edge = cyc + 1;
        @(negedge clk);
        scramble();
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput({name, "_done_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            checkOutput({name, "_result"},  result, lit);
            checkOutput({name, "_model"},   exp_result, lit);
            checkOutput({name, "_latency"}, cyc - acc_edge, lat);
            checkOutput({name, "_wb_addr"}, {27'd0, wb_addr}, {27'd0, rd});
            checkOutput({name, "_wb_en"},   {31'd0, wb_en}, {31'd0, (rd != 5'd0)});
        end
    endtask

    initial begin
        int ndone;
        logic [31:0] last_res;
        int base_acc;

        rst = 1'b0;
        scramble();
        repeat (3) @(negedge clk);
        check_en = 1'b1;
        checkOutput("reset_busy",   {31'd0, busy}, 32'd0);
        checkOutput("reset_done",   {31'd0, done}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        runOp("divu_20_3",  F3_DIVU, 32'd20,         32'd3,          5'd5,  32'd6,          33);
        runOp("div_m7_2",   F3_DIV,  32'hFFFF_FFF9,  32'd2,          5'd1,  32'hFFFF_FFFD,  33);
        runOp("rem_m7_2",   F3_REM,  32'hFFFF_FFF9,  32'd2,          5'd2,  32'hFFFF_FFFF,  33);
        runOp("remu_f9_2",  F3_REMU, 32'hFFFF_FFF9,  32'd2,          5'd3,  32'd1,          33);
        runOp("divu_5_0",   F3_DIVU, 32'd5,          32'd0,          5'd4,  32'hFFFF_FFFF,  1);
        runOp("remu_5_0",   F3_REMU, 32'd5,          32'd0,          5'd6,  32'd5,          1);
        runOp("div_ovf",    F3_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd7,  32'h8000_0000,  1);
        runOp("rem_ovf",    F3_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'd0,          1);
        runOp("div_m7_0",   F3_DIV,  32'hFFFF_FFF9,  32'd0,          5'd9,  32'hFFFF_FFFF,  1);
        runOp("rem_m7_m2",  F3_REM,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  5'd10, 32'hFFFF_FFFF,  33);
        runOp("div_9_3_x0", F3_DIV,  32'd9,          32'd3,          5'd0,  32'd3,          33);

        // MUL-group request must not start anything
        @(negedge clk);
        applyStimulus(3'b000, 32'd6, 32'd7, 5'd11);
        @(negedge clk);
        scramble();
        repeat (3) @(negedge clk);
        checkOutput("mul_ignored_busy", {31'd0, busy}, 32'd0);

        // Starts during CALC are ignored; only one done with the first result
        @(negedge clk);
        applyStimulus(F3_DIVU, 32'd1000, 32'd10, 5'd12);
        base_acc = cyc + 1;
        ndone = 0;
        last_res = '0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            scramble();
            if (j == 4 || j == 19) applyStimulus(F3_DIV, 32'd77, 32'd3, 5'd13);
            if (done === 1'b1) begin
                ndone++;
                last_res = result;
            end
        end
        checkOutput("ignore_start_ndone",  ndone, 32'd1);
        checkOutput("ignore_start_result", last_res, 32'd100);

        // Reset at edge 10 of an operation aborts it
        @(negedge clk);
        applyStimulus(F3_DIVU, 32'd12345, 32'd6, 5'd14);
        base_acc = cyc + 1;
        ndone = 0;
        for (int j = 1; j <= 45; j++) begin
            @(negedge clk);
            scramble();
            rst = (j == 9) ? 1'b0 : 1'b1;
            if (j == 10) begin
                checkOutput("abort_busy",   {31'd0, busy}, 32'd0);
                checkOutput("abort_result", result, 32'd0);
            end
            if (done === 1'b1) ndone++;
        end
        checkOutput("abort_no_done", ndone, 32'd0);
        runOp("divu_100_7", F3_DIVU, 32'd100, 32'd7, 5'd15, 32'd14, 33);

        // Randomized traffic, biased toward the corner operands
        for (int n = 0; n < 2500; n++) begin
            @(negedge clk);
            scramble();
            rst = ($urandom_range(0, 799) != 0);
            if ($urandom_range(0, 11) == 0) begin
                start  = 1'b1;
                funct3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
                case ($urandom_range(0, 5))
                    0: rs2_data = 32'd0;
                    1: rs2_data = 32'hFFFF_FFFF;
                    2: rs2_data = 32'($urandom_range(1, 15));
                    default: rs2_data = $urandom;
                endcase
                if ($urandom_range(0, 4) == 0) rs1_data = 32'h8000_0000;
            end
        end
        @(negedge clk);
        rst = 1'b1;
        scramble();
        repeat (40) @(negedge clk);

        $display("[TB] operations accepted by model: %0d", accepted);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
